module_uart_tx: RTL
===================

# module_uart_tx

Memory-mapped UART transmitter peripheral for the single-cycle RISC-V microprocessor. The processor writes bytes through the data-memory bus, and the block serialises them onto `tx_o` as 8N1 frames at a fixed baud rate. Words are buffered in a small FIFO so software can queue several bytes without polling between each one. It sits beside data memory and is selected by the top-level address decoder.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868: clock cycles per serial bit. The minimum is 2. The default gives 115200 baud at 100 MHz.
- `FIFO_DEPTH`, default 4: number of transmit buffer entries. Must be a power of 2 and at least 2.

Ports:
- `clk_i`  in  1  system clock; all logic is on the rising edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `sel_i`  in  1  chip select from the address decoder.
- `we_i`  in  1  write enable. A write takes effect only when `sel_i` is also high.
- `addr_i`  in  4  byte offset. 0x0 is DATA, 0x4 is STATUS, and all other offsets are reserved.
- `wd_i`  in  32  write data.
- `rd_o`  out  32  read data. Combinational from `addr_i` and registered state, so single-cycle loads work.
- `tx_o`  out  1  serial line. Idles high.

## Operation
- **DATA write** (`sel_i & we_i`, `addr_i`=0x0): pushes `wd_i[7:0]` into the FIFO. Bits [31:8] are ignored.
  - If the FIFO is full, the byte is dropped and sticky `ovf` is set.
  - Fullness is the registered value. A push while full is rejected even if a pop happens in the same cycle.
- **STATUS read** (`addr_i`=0x4): `rd_o` = {28'b0, ovf, empty, full, busy}.
  - `busy` is 1 whenever the FSM is not in IDLE.
- **DATA read**: returns 0.
- **Reserved offsets**: reads return 0 and writes are ignored.
- **STATUS write**: with `wd_i[3]`=1, clears `ovf`. All other bits are ignored.
- **FSM states**: IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is not empty, pop the head into the shift register, go to START, and drive `tx_o`=0.
  - START: hold `tx_o`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: send 8 bits LSB first, each for `CLKS_PER_BIT` cycles, using a 3-bit bit index. After bit 7, go to STOP.
  - STOP: hold `tx_o`=1 for `CLKS_PER_BIT` cycles. At the end, if the FIFO is not empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- **Baud counter**: counts 0..`CLKS_PER_BIT`-1 and clears on every state change. It is `$clog2(CLKS_PER_BIT)` bits wide.
- **FIFO**: pointers wrap modulo `FIFO_DEPTH`. The count is one bit wider than the pointers. A simultaneous push and pop on a non-full FIFO leaves the count unchanged.

## Timing
- **Reset values** (`rst_ni` low, asynchronous): `tx_o`=1, state IDLE, FIFO empty, `ovf`=0, baud counter 0, bit index 0. `rd_o` then reads 0x4 at STATUS.
- **Start latency**: a DATA write at edge k makes `empty`=0 after k. Edge k+1 pops the byte, and `tx_o` falls after k+1.
- **Frame length**: exactly 10·`CLKS_PER_BIT` cycles. Back-to-back frames have no gap.
- **Reset mid-frame**: `tx_o` returns high immediately, and the queued bytes and the partial frame are discarded.
- **Push during final STOP cycle into an empty FIFO**: the byte is not yet visible at the pop, so the FSM goes to IDLE and starts the byte one cycle later.

## Configuration
- `UART_TX_FIFO_EN`
  - Defined: the FIFO of `FIFO_DEPTH` entries described above.
  - Undefined: `FIFO_DEPTH` is ignored and a single holding register is used.
    - `full` equals not `empty`.
    - Pushing while the holding register is occupied drops the byte and sets `ovf`.
    - Frame timing and the register map are identical.

## Structure
- Package `uart_pkg`:
  - `uart_tx_state_e` enum (IDLE, START, DATA, STOP).
  - Offset constants `UART_DATA_OFS`=4'h0 and `UART_STATUS_OFS`=4'h4.
  - Status bit indices `ST_BUSY`=0, `ST_FULL`=1, `ST_EMPTY`=2, `ST_OVF`=3.
- Sub-module `module_uart_fifo`:
  - Synchronous FIFO with asynchronous active-low reset.
  - Ports: push/pop/data in/data out/full/empty.
  - Instantiated only under `UART_TX_FIFO_EN`.

## Test plan
Use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=4 throughout.
- **Reset**: assert `rst_ni`=0 mid-frame → `tx_o`=1 immediately; STATUS reads 0x4 after release.
- **Single byte**: write 0xA5 → `tx_o` after k+1 is 0 for 4 cycles, then 1,0,1,0,0,1,0,1 for 4 cycles each, then 1; total 40 cycles; then `busy`=0.
- **Back-to-back**: write 0x01 and 0x80 on consecutive cycles → two frames with no idle cycle between the stop bit and the second start bit.
- **Overflow**: 6 consecutive writes 0x10..0x15 → 0x10 is popped immediately and 0x11..0x14 fill the FIFO; 0x15 is dropped; STATUS = 0xB (ovf, full, busy); the line carries 0x10..0x14 only; writing STATUS with 0x8 clears `ovf`.
- **Reserved and unselected accesses**: write 0x55 to offset 0x8, and write to 0x0 with `sel_i`=0 → no frame is sent and STATUS stays at 0x4.
- **Build without `UART_TX_FIFO_EN`**: two consecutive writes → the second is dropped, `ovf`=1, and only one frame is sent.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the memory-mapped UART transmitter.
//   uart_tx_state_e : transmitter FSM states
//   UART_*_OFS      : register byte offsets on the data-memory bus
//   ST_*            : bit positions inside the STATUS word
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_e;

    localparam logic [3:0] UART_DATA_OFS   = 4'h0;
    localparam logic [3:0] UART_STATUS_OFS = 4'h4;

    localparam int ST_BUSY  = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_EMPTY = 2;
    localparam int ST_OVF   = 3;

endpackage

// File: rtl/module_uart_fifo.sv
// ---------------------------------------------------------------------------
// module_uart_fifo
// Small synchronous FIFO used as the UART transmit buffer.
// Ports:
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset (empties the FIFO)
//   i_push  : write i_data (ignored when full)
//   i_pop   : discard the head entry (ignored when empty)
//   i_data  : write data
//   o_data  : head entry, valid while o_empty is low (look-ahead read)
//   o_full  : all DEPTH entries occupied
//   o_empty : no entries
// DEPTH must be a power of two, at least 2, so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module module_uart_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int          PW      = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    // One bit wider than the pointers so full and empty are distinguishable.
    logic [PW:0]      r_count;

    logic w_push_ok;
    logic w_pop_ok;

    assign o_full    = (r_count == DEPTH_C);
    assign o_empty   = (r_count == '0);
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;

    // The transmitter loads its shift register in the same cycle it pops,
    // so the head entry is presented combinationally.
    assign o_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk_i) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (PW + 1)'(1);
                2'b01:   r_count <= r_count - (PW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/module_uart_tx.sv
// ---------------------------------------------------------------------------
// module_uart_tx
// Memory-mapped 8N1 UART transmitter for the single-cycle RISC-V core.
// Software writes bytes to DATA (offset 0x0); they are queued and shifted out
// LSB first on tx_o. STATUS (offset 0x4) reads {28'b0, ovf, empty, full, busy};
// writing STATUS with bit 3 set clears the sticky overflow flag.
//
// Build option: define UART_TX_FIFO_EN to buffer FIFO_DEPTH bytes in
// module_uart_fifo. Without it a single holding register is used
// (full == !empty) and FIFO_DEPTH has no effect.
//
// Ports:
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   sel_i  : chip select from the address decoder
//   we_i   : write enable (qualified by sel_i)
//   addr_i : byte offset within the peripheral
//   wd_i   : write data
//   rd_o   : read data, combinational from addr_i and registered state
//   tx_o   : serial output, idles high
// ---------------------------------------------------------------------------
module module_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        sel_i,
    input  logic        we_i,
    input  logic [3:0]  addr_i,
    input  logic [31:0] wd_i,
    output logic [31:0] rd_o,
    output logic        tx_o
);

    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    uart_tx_state_e r_state;
    logic [CW-1:0]  r_baud;
    logic [2:0]     r_bit;
    logic [7:0]     r_shift;
    logic           r_tx;
    logic           r_ovf;

    logic       w_wr_data;
    logic       w_wr_status;
    logic       w_push;
    logic       w_pop;
    logic       w_full;
    logic       w_empty;
    logic       w_baud_done;
    logic [7:0] w_head;
    logic       w_unused;

    // Only the low byte of a DATA write is transmitted.
    assign w_unused = ^wd_i[31:8];

    assign w_wr_data   = sel_i & we_i & (addr_i == UART_DATA_OFS);
    assign w_wr_status = sel_i & we_i & (addr_i == UART_STATUS_OFS);
    assign w_push      = w_wr_data;
    assign w_baud_done = (r_baud == BAUD_LAST);

    // A byte leaves the buffer when the line is idle, or at the last cycle
    // of a stop bit so the next start bit follows without a gap.
    assign w_pop = ~w_empty & ((r_state == IDLE) | ((r_state == STOP) & w_baud_done));

`ifdef UART_TX_FIFO_EN
    module_uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (wd_i[7:0]),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );
`else
    localparam int unused_fifo_depth = FIFO_DEPTH;

    logic [7:0] r_hold;
    logic       r_hold_valid;

    assign w_head  = r_hold;
    assign w_full  = r_hold_valid;
    assign w_empty = ~r_hold_valid;

    // A pop needs an occupied register and a push needs an empty one, so the
    // two can never coincide; a push during a pop is dropped as overflow.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
        end else if (w_pop) begin
            r_hold_valid <= 1'b0;
        end else if (w_push && !r_hold_valid) begin
            r_hold       <= wd_i[7:0];
            r_hold_valid <= 1'b1;
        end
    end
`endif

    // Sticky overflow: set on a DATA write while the registered full flag is
    // high, cleared only by software.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ovf <= 1'b0;
        end else if (w_wr_data && w_full) begin
            r_ovf <= 1'b1;
        end else if (w_wr_status && wd_i[ST_OVF]) begin
            r_ovf <= 1'b0;
        end
    end

    // Transmit FSM. tx_o is registered and updated together with the state,
    // so each bit starts on the same edge the state/bit index changes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    r_baud <= '0;
                    r_bit  <= '0;
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_tx    <= 1'b0;
                        r_state <= START;
                    end else begin
                        r_tx <= 1'b1;
                    end
                end
                START: begin
                    if (w_baud_done) begin
                        r_baud  <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= DATA;
                    end else begin
                        r_baud <= r_baud + CW'(1);
                    end
                end
                DATA: begin
                    if (w_baud_done) begin
                        r_baud  <= '0;
                        // Shift right so bit 0 of r_shift is always the bit on the line.
                        r_shift <= {1'b0, r_shift[7:1]};
                        if (r_bit == 3'd7) begin
                            r_bit   <= '0;
                            r_tx    <= 1'b1;
                            r_state <= STOP;
                        end else begin
                            r_bit <= r_bit + 3'd1;
                            r_tx  <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + CW'(1);
                    end
                end
                STOP: begin
                    if (w_baud_done) begin
                        r_baud <= '0;
                        if (w_pop) begin
                            r_shift <= w_head;
                            r_tx    <= 1'b0;
                            r_state <= START;
                        end else begin
                            r_tx    <= 1'b1;
                            r_state <= IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + CW'(1);
                    end
                end
                default: begin
                    r_baud  <= '0;
                    r_bit   <= '0;
                    r_tx    <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign tx_o = r_tx;

    always_comb begin
        rd_o = '0;
        if (addr_i == UART_STATUS_OFS) begin
            rd_o[ST_OVF]   = r_ovf;
            rd_o[ST_EMPTY] = w_empty;
            rd_o[ST_FULL]  = w_full;
            rd_o[ST_BUSY]  = (r_state != IDLE);
        end
    end

endmodule
